// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex.
// Set FIFO_WIDTH and FIFO_DEPTH to the same values as the attached FIFO.
interface sync_fifo_flex_if #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic                  i_push;
   logic [FIFO_WIDTH-1:0] in_fifo;
   logic                  i_pop;
   logic                  i_flush;
   logic [CNT_W-1:0]      i_afull_th;
   logic [CNT_W-1:0]      i_aempty_th;
   logic                  i_clr_err;
   logic [FIFO_WIDTH-1:0] out_fifo;
   logic                  o_valid;
   logic                  is_fifo_full;
   logic                  is_fifo_empty;
   logic                  o_almost_full;
   logic                  o_almost_empty;
   logic [CNT_W-1:0]      o_count;
   logic                  o_overflow;
   logic                  o_underflow;

   // Producer/consumer side: drives requests and thresholds, observes status.
   modport master (
      output i_push, in_fifo, i_pop, i_flush, i_afull_th, i_aempty_th, i_clr_err,
      input  out_fifo, o_valid, is_fifo_full, is_fifo_empty, o_almost_full,
             o_almost_empty, o_count, o_overflow, o_underflow
   );

   // FIFO side.
   modport slave (
      input  i_push, in_fifo, i_pop, i_flush, i_afull_th, i_aempty_th, i_clr_err,
      output out_fifo, o_valid, is_fifo_full, is_fifo_empty, o_almost_full,
             o_almost_empty, o_count, o_overflow, o_underflow
   );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, exact occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// build-time choice between registered read and first-word-fall-through.
// The bus interface must be instantiated with matching FIFO_WIDTH/FIFO_DEPTH.
module sync_fifo_flex #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FWFT       = 0
) (
   input logic             clk,
   input logic             rst,
   sync_fifo_flex_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [FIFO_WIDTH-1:0] ram [FIFO_DEPTH];
   logic                  overflow_q;
   logic                  underflow_q;

   logic pop_ok_c;
   logic push_ok_c;
   logic do_pop_c;
   logic do_push_c;
   logic ovf_set_c;
   logic udf_set_c;

   // Pointer increment with wrap at FIFO_DEPTH-1; depth need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Accept decisions from registered count; flush suppresses both transfers and error setting.
   always_comb begin
      pop_ok_c  = 1'b0;
      push_ok_c = 1'b0;
      do_pop_c  = 1'b0;
      do_push_c = 1'b0;
      ovf_set_c = 1'b0;
      udf_set_c = 1'b0;

      pop_ok_c  = bus.i_pop & (count != '0);
      push_ok_c = bus.i_push & ((count != CNT_FULL) | pop_ok_c);
      do_pop_c  = pop_ok_c & ~bus.i_flush;
      do_push_c = push_ok_c & ~bus.i_flush;
      ovf_set_c = ~bus.i_flush & bus.i_push & ~push_ok_c;
      udf_set_c = ~bus.i_flush & bus.i_pop & (count == '0);
   end

   // Pointers and occupancy; flush returns everything to the empty state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push_c) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop_c)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push_c && !do_pop_c)      count <= count + CNT_W'(1);
         else if (do_pop_c && !do_push_c) count <= count - CNT_W'(1);
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push_c) ram[wr_ptr] <= bus.in_fifo;
   end

   // Sticky error flags: a new error in the same cycle beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= ovf_set_c | (overflow_q & ~bus.i_clr_err);
         underflow_q <= udf_set_c | (underflow_q & ~bus.i_clr_err);
      end
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [FIFO_WIDTH-1:0] out_q;
         logic                  valid_q;

         // Registered read: data lands one cycle after an accepted pop and then holds.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_q   <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= do_pop_c;
               if (do_pop_c) out_q <= ram[rd_ptr];
            end
         end

         assign bus.out_fifo = out_q;
         assign bus.o_valid  = valid_q;
      end else begin : g_fwft
         // Head word is presented directly whenever the FIFO holds data.
         assign bus.out_fifo = ram[rd_ptr];
         assign bus.o_valid  = (count != '0);
      end
   endgenerate

   // Status derived from registered count; thresholds apply the same cycle they change.
   assign bus.o_count        = count;
   assign bus.is_fifo_full   = (count == CNT_FULL);
   assign bus.is_fifo_empty  = (count == '0);
   assign bus.o_almost_full  = (count >= bus.i_afull_th);
   assign bus.o_almost_empty = (count <= bus.i_aempty_th);
   assign bus.o_overflow     = overflow_q;
   assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: default build, a depth-5 build for
// pointer wrap, and a FWFT build.
module tb_sync_fifo_flex;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   sync_fifo_flex_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if0 ();
   sync_fifo_flex_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) if1 ();
   sync_fifo_flex_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if2 ();

   sync_fifo_flex #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
   sync_fifo_flex #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
   sync_fifo_flex #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      if0.i_push = 1'b0; if0.in_fifo = '0; if0.i_pop = 1'b0; if0.i_flush = 1'b0;
      if0.i_afull_th = 4'd6; if0.i_aempty_th = 4'd1; if0.i_clr_err = 1'b0;
      if1.i_push = 1'b0; if1.in_fifo = '0; if1.i_pop = 1'b0; if1.i_flush = 1'b0;
      if1.i_afull_th = 3'd4; if1.i_aempty_th = 3'd1; if1.i_clr_err = 1'b0;
      if2.i_push = 1'b0; if2.in_fifo = '0; if2.i_pop = 1'b0; if2.i_flush = 1'b0;
      if2.i_afull_th = 4'd6; if2.i_aempty_th = 4'd1; if2.i_clr_err = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_count", 32'(if0.o_count), 32'd0);
      chk("rst_empty", 32'(if0.is_fifo_empty), 32'd1);
      chk("rst_full", 32'(if0.is_fifo_full), 32'd0);
      chk("rst_valid", 32'(if0.o_valid), 32'd0);
      chk("rst_out", 32'(if0.out_fifo), 32'd0);
      chk("rst_ovf", 32'(if0.o_overflow), 32'd0);
      chk("rst_udf", 32'(if0.o_underflow), 32'd0);
      rst = 1'b0;

      // Fill to full, then one dropped push
      for (int i = 1; i <= 8; i++) begin
         if0.i_push = 1'b1; if0.in_fifo = 16'(i);
         tick();
         chk("fill_count", 32'(if0.o_count), 32'(i));
         chk("fill_full", 32'(if0.is_fifo_full), (i == 8) ? 32'd1 : 32'd0);
         chk("fill_afull", 32'(if0.o_almost_full), (i >= 6) ? 32'd1 : 32'd0);
      end
      if0.in_fifo = 16'h0009;
      tick();
      if0.i_push = 1'b0;
      chk("ovf_set", 32'(if0.o_overflow), 32'd1);
      chk("ovf_count", 32'(if0.o_count), 32'd8);
      if0.i_afull_th = 4'd9;
      #1;
      chk("afull_th_above_depth", 32'(if0.o_almost_full), 32'd0);
      if0.i_afull_th = 4'd6;

      // Drain in order, then pop on empty
      for (int i = 1; i <= 8; i++) begin
         if0.i_pop = 1'b1;
         tick();
         chk("drain_valid", 32'(if0.o_valid), 32'd1);
         chk("drain_out", 32'(if0.out_fifo), 32'(i));
         chk("drain_count", 32'(if0.o_count), 32'(8 - i));
      end
      tick();
      if0.i_pop = 1'b0;
      chk("udf_set", 32'(if0.o_underflow), 32'd1);
      chk("udf_valid", 32'(if0.o_valid), 32'd0);
      chk("udf_out_hold", 32'(if0.out_fifo), 32'h0008);
      chk("udf_empty", 32'(if0.is_fifo_empty), 32'd1);
      chk("aempty_at_0", 32'(if0.o_almost_empty), 32'd1);
      if0.i_afull_th = 4'd0;
      #1;
      chk("afull_th_zero", 32'(if0.o_almost_full), 32'd1);
      if0.i_afull_th = 4'd6;
      if0.i_clr_err = 1'b1;
      tick();
      if0.i_clr_err = 1'b0;
      chk("clr_ovf", 32'(if0.o_overflow), 32'd0);
      chk("clr_udf", 32'(if0.o_underflow), 32'd0);

      // Push+pop on full
      for (int i = 0; i < 8; i++) begin
         if0.i_push = 1'b1; if0.in_fifo = 16'(16'h0010 + i);
         tick();
      end
      if0.in_fifo = 16'hAAAA; if0.i_pop = 1'b1;
      tick();
      if0.i_push = 1'b0;
      chk("pp_full_count", 32'(if0.o_count), 32'd8);
      chk("pp_full_ovf", 32'(if0.o_overflow), 32'd0);
      chk("pp_full_out", 32'(if0.out_fifo), 32'h0010);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("pp_drain_out", 32'(if0.out_fifo), (k < 8) ? 32'(16'h0010 + k) : 32'hAAAA);
      end
      if0.i_pop = 1'b0;
      chk("pp_drain_empty", 32'(if0.is_fifo_empty), 32'd1);

      // Push+pop on empty
      if0.i_push = 1'b1; if0.in_fifo = 16'h5555; if0.i_pop = 1'b1;
      tick();
      if0.i_pop = 1'b0;
      chk("pp_empty_count", 32'(if0.o_count), 32'd1);
      chk("pp_empty_udf", 32'(if0.o_underflow), 32'd1);
      chk("pp_empty_valid", 32'(if0.o_valid), 32'd0);
      if0.in_fifo = 16'h0022; tick();
      if0.in_fifo = 16'h0023; tick();
      chk("pre_flush_count", 32'(if0.o_count), 32'd3);

      // Flush with a push in the same cycle
      if0.i_flush = 1'b1; if0.in_fifo = 16'h0099;
      tick();
      if0.i_flush = 1'b0; if0.i_push = 1'b0;
      chk("flush_count", 32'(if0.o_count), 32'd0);
      chk("flush_empty", 32'(if0.is_fifo_empty), 32'd1);
      chk("flush_ovf", 32'(if0.o_overflow), 32'd0);
      chk("flush_udf_kept", 32'(if0.o_underflow), 32'd1);
      chk("flush_valid", 32'(if0.o_valid), 32'd0);
      chk("flush_out_hold", 32'(if0.out_fifo), 32'hAAAA);
      if0.i_clr_err = 1'b1; tick(); if0.i_clr_err = 1'b0;
      if0.i_flush = 1'b1; if0.i_pop = 1'b1;
      tick();
      if0.i_flush = 1'b0; if0.i_pop = 1'b0;
      chk("flush_pop_no_udf", 32'(if0.o_underflow), 32'd0);
      if0.i_push = 1'b1; if0.in_fifo = 16'h0077; tick();
      if0.i_push = 1'b0; if0.i_pop = 1'b1; tick();
      if0.i_pop = 1'b0;
      chk("post_flush_out", 32'(if0.out_fifo), 32'h0077);

      // Asynchronous reset mid-stream
      if0.i_push = 1'b1; if0.in_fifo = 16'h0031; tick();
      if0.in_fifo = 16'h0032; tick();
      if0.i_push = 1'b0; if0.i_pop = 1'b1; tick();
      if0.i_pop = 1'b0;
      chk("pre_rst_out", 32'(if0.out_fifo), 32'h0031);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count", 32'(if0.o_count), 32'd0);
      chk("arst_out", 32'(if0.out_fifo), 32'd0);
      chk("arst_valid", 32'(if0.o_valid), 32'd0);
      chk("arst_empty", 32'(if0.is_fifo_empty), 32'd1);
      tick();
      rst = 1'b0;

      // Depth 5: 23 words through with occupancy held at 3
      for (int i = 0; i < 3; i++) begin
         if1.i_push = 1'b1; if1.in_fifo = 16'(16'h0100 + i);
         tick();
      end
      if1.i_pop = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if1.in_fifo = 16'(16'h0103 + i);
         tick();
         chk("d5_out", 32'(if1.out_fifo), 32'(16'h0100 + i));
         chk("d5_count", 32'(if1.o_count), 32'd3);
      end
      if1.i_push = 1'b0;
      for (int i = 20; i < 23; i++) begin
         tick();
         chk("d5_tail_out", 32'(if1.out_fifo), 32'(16'h0100 + i));
         chk("d5_tail_valid", 32'(if1.o_valid), 32'd1);
      end
      if1.i_pop = 1'b0;
      chk("d5_empty", 32'(if1.is_fifo_empty), 32'd1);
      chk("d5_ovf", 32'(if1.o_overflow), 32'd0);
      chk("d5_udf", 32'(if1.o_underflow), 32'd0);

      // FWFT build
      chk("fwft_idle_valid", 32'(if2.o_valid), 32'd0);
      if2.i_push = 1'b1; if2.in_fifo = 16'h1234;
      tick();
      if2.i_push = 1'b0;
      chk("fwft_valid", 32'(if2.o_valid), 32'd1);
      chk("fwft_out", 32'(if2.out_fifo), 32'h1234);
      if2.i_pop = 1'b1;
      tick();
      if2.i_pop = 1'b0;
      chk("fwft_pop_valid", 32'(if2.o_valid), 32'd0);
      chk("fwft_pop_count", 32'(if2.o_count), 32'd0);
      if2.i_push = 1'b1; if2.in_fifo = 16'hABCD; tick();
      if2.in_fifo = 16'h5678; tick();
      if2.i_push = 1'b0;
      chk("fwft_head_hold", 32'(if2.out_fifo), 32'hABCD);
      if2.i_pop = 1'b1; tick();
      chk("fwft_next_head", 32'(if2.out_fifo), 32'h5678);
      chk("fwft_next_valid", 32'(if2.o_valid), 32'd1);
      tick();
      if2.i_pop = 1'b0;
      chk("fwft_drained", 32'(if2.o_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
